matmul_engine: RTL and testbench

Sequential 3x3 matrix multiplier that sits directly downstream of the serial operand loader. When the loader signals that both operand matrices are captured, the block computes C = A·B with one shared 8x8 multiplier, one MAC per cycle. It streams each 18-bit result element out as three bytes over a valid/ready byte interface. It runs once per reset and then holds a finished flag.

---
 rtl/matmul_pkg.sv | 37 +++
 rtl/matmul_engine_result_serializer.sv | 73 +++++++
 rtl/matmul_engine.sv | 144 ++++++++++++++
 tb/tb_matmul_engine.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared constants and types for the 3x3 matrix multiply path. The serial
// operand loader also draws DIM and DATA_W from here so that both sides
// agree on the operand layout.
//   DIM        matrix dimension
//   DATA_W     operand width
//   ACC_W      accumulator width, sized so a full dot product cannot overflow
//   OUT_BYTES  bytes emitted per result element
//   state_e    engine FSM states
//   rm_idx     row-major flat index helper
// ---------------------------------------------------------------------------
package matmul_pkg;

    localparam int DIM        = 3;
    localparam int DATA_W     = 8;
    localparam int ACC_W      = 2 * DATA_W + $clog2(DIM);
    localparam int OUT_BYTES  = (ACC_W + 7) / 8;
    localparam int SREG_W     = OUT_BYTES * 8;
    localparam int CNT_W      = $clog2(DIM);
    localparam int IDX_W      = $clog2(DIM * DIM);
    localparam int BYTE_CNT_W = $clog2(OUT_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    // Flat position of element (r, c) in a row-major DIM x DIM matrix
    function automatic logic [IDX_W-1:0] rm_idx(input logic [CNT_W-1:0] r,
                                                input logic [CNT_W-1:0] c);
        return IDX_W'(r) * IDX_W'(DIM) + IDX_W'(c);
    endfunction

endpackage

// File: rtl/matmul_engine_result_serializer.sv
// ---------------------------------------------------------------------------
// result_serializer
// Takes one result word and hands it downstream a byte at a time, MSB first,
// over a valid/ready interface.
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   load_i       strobe: capture word_i and start emitting it
//   word_i       zero-extended result word
//   ready_i      downstream accepts data_o this cycle
//   valid_o      data_o holds a valid byte
//   data_o       current byte (0 when not valid)
//   last_byte_o  pulses in the cycle the final byte of the word is accepted
// ---------------------------------------------------------------------------
module result_serializer
    import matmul_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [SREG_W-1:0] word_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [7:0]        data_o,
    output logic              last_byte_o
);

    logic [SREG_W-1:0]     sreg_q, sreg_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  accept;

    // Next-state: a load restarts the word; each accepted byte shifts the
    // next one into the top slot, and the final one drops valid.
    always_comb begin
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        accept      = valid_q && ready_i;
        last_byte_o = accept && (cnt_q == BYTE_CNT_W'(OUT_BYTES - 1));

        if (load_i) begin
            sreg_d  = word_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (accept) begin
            sreg_d = {sreg_q[SREG_W-9:0], 8'h00};
            if (last_byte_o) begin
                cnt_d   = '0;
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Byte bus is forced to zero whenever nothing is being offered
    assign valid_o = valid_q;
    assign data_o  = valid_q ? sreg_q[SREG_W-1 -: 8] : 8'h00;

endmodule

// File: rtl/matmul_engine.sv
// ---------------------------------------------------------------------------
// matmul_engine
// Computes C = A*B for 3x3 unsigned 8-bit matrices with a single shared
// multiplier (one MAC per cycle), then streams each 18-bit element as three
// bytes, MSB first. Runs once per reset and then parks with finished high.
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      operands captured (level from the loader)
//   a_i, b_i     row-major operand matrices, element n at [n*8 +: 8]
//   out_ready_i  downstream accepts data_out_o this cycle
//   data_out_o   current result byte
//   out_valid_o  data_out_o holds a valid byte
//   busy_o       computing or sending
//   finished_o   all elements delivered
// ---------------------------------------------------------------------------
module matmul_engine
    import matmul_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [DIM*DIM*DATA_W-1:0]  a_i,
    input  logic [DIM*DIM*DATA_W-1:0]  b_i,
    input  logic                       out_ready_i,
    output logic [7:0]                 data_out_o,
    output logic                       out_valid_o,
    output logic                       busy_o,
    output logic                       finished_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0]   acc_q, acc_d;

    logic [DATA_W-1:0]   aEl [DIM*DIM];
    logic [DATA_W-1:0]   bEl [DIM*DIM];
    logic [DATA_W-1:0]   aSel, bSel;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    accSum;
    logic                loadWord;
    logic                lastByte;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIM - 1);

    // Operand select and the shared multiplier: A[i][k] * B[k][j]
    always_comb begin
        for (int n = 0; n < DIM * DIM; n++) begin
            aEl[n] = a_i[n*DATA_W +: DATA_W];
            bEl[n] = b_i[n*DATA_W +: DATA_W];
        end
        aSel   = aEl[rm_idx(i_q, k_q)];
        bSel   = bEl[rm_idx(k_q, j_q)];
        prod   = (2*DATA_W)'(aSel) * (2*DATA_W)'(bSel);
        accSum = acc_q + ACC_W'(prod);
    end

    // FSM next-state and counter/accumulator update. The final MAC of an
    // element hands accSum (not acc_q) to the serializer so no extra cycle
    // is spent.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        loadWord = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = MAC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            MAC: begin
                acc_d = accSum;
                if (k_q == LAST_IDX) begin
                    loadWord = 1'b1;
                    state_d  = SEND;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            SEND: begin
                if (lastByte) begin
                    if (i_q == LAST_IDX && j_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = MAC;
                        k_d     = '0;
                        acc_d   = '0;
                        if (j_q == LAST_IDX) begin
                            j_d = '0;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and accumulator
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    result_serializer u_serializer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (loadWord),
        .word_i      (SREG_W'(accSum)),
        .ready_i     (out_ready_i),
        .valid_o     (out_valid_o),
        .data_o      (data_out_o),
        .last_byte_o (lastByte)
    );

    assign busy_o     = (state_q == MAC) || (state_q == SEND);
    assign finished_o = (state_q == DONE);

endmodule

// File: tb/tb_matmul_engine.sv
// ---------------------------------------------------------------------------
// tb_matmul_engine
// Scoreboard bench: expected bytes are queued when a run is issued and a
// negedge monitor pops and compares each byte as it is accepted.
// ---------------------------------------------------------------------------
module tb_matmul_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [71:0] a, b;
    logic        outReady;
    logic [7:0]  dataOut;
    logic        outValid;
    logic        busy;
    logic        finished;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  expQ[$];
    int          bytesSeen = 0;
    logic        stallPending = 1'b0;
    logic [7:0]  stallData;

    int idElemsA[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int seqElems[9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int seqResult[9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    int fullOps[9]   = '{default: 255};
    int fullResult[9] = '{default: 195075};

    always #5 clk = ~clk;

    matmul_engine dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .a_i         (a),
        .b_i         (b),
        .out_ready_i (outReady),
        .data_out_o  (dataOut),
        .out_valid_o (outValid),
        .busy_o      (busy),
        .finished_o  (finished)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [71:0] packMat(input int v[9]);
        logic [71:0] m;
        m = '0;
        for (int n = 0; n < 9; n++) m[n*8 +: 8] = 8'(v[n]);
        return m;
    endfunction

    // Queue the three MSB-first bytes of each expected element
    task automatic pushElems(input int e[9]);
        logic [23:0] w;
        for (int n = 0; n < 9; n++) begin
            w = 24'(e[n]);
            expQ.push_back(w[23:16]);
            expQ.push_back(w[15:8]);
            expQ.push_back(w[7:0]);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: byte acceptance, stall stability, zero bus when idle,
    // busy/finished exclusivity
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (stallPending) begin
                checkOutput("stall_valid_hold", {31'b0, outValid}, 32'd1);
                checkOutput("stall_data_hold", {24'b0, dataOut}, {24'b0, stallData});
                stallPending = 1'b0;
            end
            if (outValid && outReady) begin
                checkOutput("byte_expected", {31'b0, expQ.size() > 0}, 32'd1);
                if (expQ.size() > 0)
                    checkOutput("stream_byte", {24'b0, dataOut}, {24'b0, expQ.pop_front()});
                bytesSeen++;
            end else if (outValid && !outReady) begin
                stallPending = 1'b1;
                stallData    = dataOut;
            end
            if (!outValid)
                checkOutput("idle_data_zero", {24'b0, dataOut}, 32'd0);
            checkOutput("busy_finished_excl", {31'b0, busy && finished}, 32'd0);
        end
    end

    // Assert reset asynchronously and verify outputs clear at once
    task automatic applyReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_data_out", {24'b0, dataOut}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_finished", {31'b0, finished}, 32'd0);
        expQ.delete();
        bytesSeen    = 0;
        stallPending = 1'b0;
        start        = 1'b0;
        outReady     = 1'b1;
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
    endtask

    // One full run. mode 0: out_ready held high; mode 1: 5-cycle stall on a
    // middle byte, then random out_ready.
    task automatic applyStimulus(input int am[9], input int bm[9], input int elems[9],
                                 input int mode, input bit timing);
        int finishEdge;
        int stallLeft;
        bit stallDone;
        finishEdge = -1;
        stallLeft  = 0;
        stallDone  = 1'b0;
        pushElems(elems);
        bytesSeen = 0;
        a         = packMat(am);
        b         = packMat(bm);
        outReady  = 1'b1;
        start     = 1'b1;
        stepCycle();
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            stepCycle();
            if (timing && cyc <= 3)
                checkOutput("valid_rise", {31'b0, outValid}, {31'b0, cyc == 3});
            if (finished) begin
                finishEdge = cyc;
                break;
            end
            if (mode == 1) begin
                if (stallLeft > 0) begin
                    outReady = 1'b0;
                    stallLeft--;
                end else if (!stallDone && outValid && bytesSeen == 13) begin
                    outReady  = 1'b0;
                    stallLeft = 4;
                    stallDone = 1'b1;
                end else if (stallDone) begin
                    outReady = 1'($urandom_range(0, 1));
                end else begin
                    outReady = 1'b1;
                end
            end
        end
        checkOutput("finished_reached", {31'b0, finished}, 32'd1);
        if (timing) checkOutput("finish_edge", finishEdge, 32'd54);
        if (mode == 1) checkOutput("stall_applied", {31'b0, stallDone}, 32'd1);
        checkOutput("byte_count", bytesSeen, 32'd27);
        checkOutput("queue_drained", expQ.size(), 32'd0);
        outReady = 1'b1;
    endtask

    // Start a run and stop after nCycles edges, leaving it mid-operation
    task automatic startPartial(input int am[9], input int bm[9], input int elems[9],
                                input int nCycles, input bit expectValid);
        pushElems(elems);
        bytesSeen = 0;
        a         = packMat(am);
        b         = packMat(bm);
        outReady  = 1'b1;
        start     = 1'b1;
        repeat (nCycles) stepCycle();
        checkOutput("partial_busy", {31'b0, busy}, 32'd1);
        checkOutput("partial_valid", {31'b0, outValid}, {31'b0, expectValid});
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        outReady = 1'b1;
        #2;
        applyReset();

        $display("[TB] identity run");
        applyStimulus(idElemsA, seqElems, seqElems, 0, 1'b1);
        applyReset();

        $display("[TB] sequential operands");
        applyStimulus(seqElems, seqElems, seqResult, 0, 1'b1);
        applyReset();

        $display("[TB] full-scale operands");
        applyStimulus(fullOps, fullOps, fullResult, 0, 1'b1);
        applyReset();

        $display("[TB] backpressure");
        applyStimulus(seqElems, seqElems, seqResult, 1, 1'b0);
        applyReset();

        $display("[TB] reset mid-MAC");
        startPartial(seqElems, seqElems, seqResult, 3, 1'b0);
        applyReset();
        applyStimulus(seqElems, seqElems, seqResult, 0, 1'b1);
        applyReset();

        $display("[TB] reset mid-SEND");
        startPartial(fullOps, fullOps, fullResult, 5, 1'b1);
        applyReset();
        applyStimulus(idElemsA, seqElems, seqElems, 0, 1'b1);

        $display("[TB] no restart after done");
        start = 1'b1;
        for (int n = 0; n < 20; n++) begin
            stepCycle();
            checkOutput("done_finished_hold", {31'b0, finished}, 32'd1);
            checkOutput("done_no_valid", {31'b0, outValid}, 32'd0);
        end
        checkOutput("done_byte_count", bytesSeen, 32'd27);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time guard so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
